// File: rtl/raster_tile_fetch.sv
// raster_tile_fetch: walks the tile buffer, issues credit-limited reads and
// streams the returned tile records in order with a running index.
// Optional feature: define RASTER_TILE_FETCH_PERF_EN to enable the saturating
// output back-pressure counter on perf_stalls.

package raster_tile_fetch_pkg;
    typedef struct packed {
        logic [31:0] tbuf_addr;
        logic [31:0] tile_count;
        logic [31:0] pbuf_addr;
        logic [31:0] pbuf_stride;
    } raster_dcrs_t;
endpackage

module raster_tile_fetch
    import raster_tile_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int TILE_BYTES  = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  raster_dcrs_t                   dcrs,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           mem_req_valid,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr,
    output logic [$clog2(MAX_PENDING)-1:0] mem_req_tag,
    input  logic                           mem_req_ready,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
    input  logic [$clog2(MAX_PENDING)-1:0] mem_rsp_tag,
    output logic                           mem_rsp_ready,
    output logic                           tile_valid,
    output logic [DATA_WIDTH-1:0]          tile_data,
    output logic [31:0]                    tile_index,
    input  logic                           tile_ready,
    output logic [31:0]                    perf_stalls
);
    localparam int TAG_WIDTH = $clog2(MAX_PENDING);
    localparam logic [TAG_WIDTH:0] FIFO_DEPTH = (TAG_WIDTH+1)'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state, state_next;
    logic                  done_next;
    logic [31:0]           tile_count_r;
    logic [31:0]           issued;
    logic [31:0]           emitted;
    logic [ADDR_WIDTH-1:0] req_addr;

    logic [DATA_WIDTH-1:0] fifo_mem [MAX_PENDING];
    logic [TAG_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [TAG_WIDTH:0]    fifo_count;

    logic start_pass, req_fire, rsp_fire, tile_fire, last_req, push, pop;
    logic [31:0] in_flight;

    // Pass-level routing info and the tag are handled positionally (in-order memory).
    logic unused_inputs;
    assign unused_inputs = ^{dcrs.pbuf_addr, dcrs.pbuf_stride, mem_rsp_tag};

    assign start_pass = (state == IDLE) && start;
    assign req_fire   = mem_req_valid && mem_req_ready;
    assign rsp_fire   = mem_rsp_valid && mem_rsp_ready;
    assign tile_fire  = tile_valid && tile_ready;
    assign last_req   = req_fire && (issued == tile_count_r - 32'd1);
    assign in_flight  = issued - emitted;

    // Credits cover both in-flight reads and FIFO occupancy, so a full FIFO
    // only sees a push in the same cycle as a pop.
    assign push = rsp_fire && ((fifo_count != FIFO_DEPTH) || tile_fire);
    assign pop  = tile_fire;

    assign busy          = (state != IDLE);
    assign mem_rsp_ready = busy;
    assign mem_req_valid = (state == FETCH) && (in_flight < 32'(MAX_PENDING));
    assign mem_req_addr  = req_addr;
    assign mem_req_tag   = issued[TAG_WIDTH-1:0];
    assign tile_valid    = (fifo_count != '0);
    assign tile_data     = fifo_mem[rd_ptr];
    assign tile_index    = emitted;

    // State register and registered done pulse.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Next-state and done decode.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (dcrs.tile_count != 32'd0) state_next = FETCH;
                    else                          done_next  = 1'b1;
                end
            end
            FETCH: begin
                if (last_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (emitted == tile_count_r) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pass parameters latched at start; issue/emit counters and running address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_count_r <= '0;
            issued       <= '0;
            emitted      <= '0;
            req_addr     <= '0;
        end else if (start_pass) begin
            tile_count_r <= dcrs.tile_count;
            issued       <= '0;
            emitted      <= '0;
            req_addr     <= ADDR_WIDTH'(dcrs.tbuf_addr);
        end else begin
            if (req_fire) begin
                issued   <= issued + 32'd1;
                req_addr <= req_addr + ADDR_WIDTH'(TILE_BYTES);
            end
            if (tile_fire) emitted <= emitted + 32'd1;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + TAG_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + TAG_WIDTH'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (TAG_WIDTH+1)'(1);
                2'b01:   fifo_count <= fifo_count - (TAG_WIDTH+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; fifo_count alone says which entries are valid.
        if (push) fifo_mem[wr_ptr] <= mem_rsp_data;
    end

`ifdef RASTER_TILE_FETCH_PERF_EN
    logic [31:0] stall_count;

    // Saturating count of cycles where a tile is offered but not taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                              stall_count <= '0;
        else if (tile_valid && !tile_ready && stall_count != '1) stall_count <= stall_count + 32'd1;
    end

    assign perf_stalls = stall_count;
`else
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_raster_tile_fetch.sv
// Self-checking bench for raster_tile_fetch: table of pass descriptors run
// against an in-order memory model and a reference of the expected stream,
// plus hand-written reset and huge-count sequences.
module tb_raster_tile_fetch;
    import raster_tile_fetch_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TB = 8;
    localparam int MP = 4;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          reset;
    raster_dcrs_t  dcrs;
    logic          start;
    logic          busy, done;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic [TW-1:0] mem_req_tag;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic          tile_valid, tile_ready;
    logic [DW-1:0] tile_data;
    logic [31:0]   tile_index;
    logic [31:0]   perf_stalls;

    raster_tile_fetch #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TILE_BYTES(TB), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset), .dcrs(dcrs), .start(start), .busy(busy), .done(done),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready),
        .tile_valid(tile_valid), .tile_data(tile_data), .tile_index(tile_index),
        .tile_ready(tile_ready), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tbuf;
        logic [31:0] cnt;
        int          req_pct;
        int          tile_pct;
        int          lat;
        int          hold;
        bit          restart;
        logic [31:0] exp_last_addr;
        logic [31:0] exp_tiles;
    } vec_t;

    typedef struct {
        logic [31:0]   addr;
        logic [TW-1:0] tag;
        int            due;
    } rsp_t;

    rsp_t rspq[$];
    int   checks   = 0;
    int   failures = 0;
    int   perf_model;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a distinct word per byte address.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5EED_F00D, ~a};
    endfunction

    function automatic raster_dcrs_t rand_dcrs();
        raster_dcrs_t d;
        d.tbuf_addr   = $urandom;
        d.tile_count  = $urandom_range(0, 20);
        d.pbuf_addr   = $urandom;
        d.pbuf_stride = $urandom;
        return d;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_rsp_ready"}, mem_rsp_ready, 0);
        check({tag, "_tile_valid"}, tile_valid, 0);
        check({tag, "_perf"}, perf_stalls, 0);
    endtask

    // Runs one pass; the model expects tile i = mem_word(tbuf + i*TILE_BYTES).
    task automatic run_pass(input vec_t v, input int abort_at,
                            output int n_tiles, output int n_reqs, output int n_done,
                            output int done_cyc, output logic [31:0] last_addr,
                            output bit saw_busy, output bit aborted);
        bit          finished;
        logic [31:0] exp_addr;
        logic [31:0] tile_addr;
        n_tiles = 0; n_reqs = 0; n_done = 0; done_cyc = -1; last_addr = '0;
        saw_busy = 0; aborted = 0; finished = 0;
        rspq.delete();
        @(negedge clk);
        dcrs = '{tbuf_addr: v.tbuf, tile_count: v.cnt, pbuf_addr: $urandom, pbuf_stride: $urandom};
        start = 1'b1; mem_req_ready = 1'b1; tile_ready = 1'b1; mem_rsp_valid = 1'b0;
        #1;
        check("idle_before_start", busy, 0);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start = v.restart && (cyc == 2);
            dcrs  = rand_dcrs();
            mem_req_ready = ($urandom_range(99) < v.req_pct);
            tile_ready    = (cyc >= v.hold) && ($urandom_range(99) < v.tile_pct);
            if (rspq.size() > 0 && rspq[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(rspq[0].addr);
                mem_rsp_tag   = rspq[0].tag;
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
                mem_rsp_tag   = '0;
            end
            #1;
            if (abort_at >= 0 && n_tiles >= abort_at) begin
                aborted = 1;
                break;
            end
            if (v.hold > 0 && cyc == v.hold) begin
                check("held_req_count", n_reqs, MP);
                check("held_req_valid", mem_req_valid, 0);
            end
            if (busy) saw_busy = 1;
            if (mem_req_valid) begin
                check("credit_limit", (n_reqs - n_tiles) < MP, 1);
                if (mem_req_ready) begin
                    exp_addr = v.tbuf + 32'(n_reqs) * 32'(TB);
                    check("req_addr", mem_req_addr, exp_addr);
                    check("req_tag", mem_req_tag, n_reqs % MP);
                    rspq.push_back('{addr: mem_req_addr, tag: mem_req_tag,
                                     due: cyc + v.lat + int'($urandom_range(0, 1))});
                    last_addr = mem_req_addr;
                    n_reqs++;
                end
            end
            if (mem_rsp_valid && mem_rsp_ready) void'(rspq.pop_front());
            if (tile_valid) begin
                tile_addr = v.tbuf + 32'(n_tiles) * 32'(TB);
                check("tile_index", tile_index, n_tiles);
                check("tile_data", tile_data, mem_word(tile_addr));
                if (tile_ready) n_tiles++;
                else            perf_model++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("busy_low_at_done", busy, 0);
                finished = 1;
            end
        end
        if (!aborted) begin
            check("pass_finished", finished, 1);
            repeat (3) begin
                @(negedge clk);
                start = 1'b0; mem_rsp_valid = 1'b0;
                #1;
                if (done) n_done++;
                if (busy) saw_busy = 1;
            end
            check("busy_after_pass", busy, 0);
`ifdef RASTER_TILE_FETCH_PERF_EN
            check("perf_stalls", perf_stalls, perf_model);
`else
            check("perf_stalls", perf_stalls, 0);
`endif
            check("rsp_queue_drained", rspq.size(), 0);
        end
    endtask

    vec_t vecs[10];

    initial begin
        int          n_tiles, n_reqs, n_done, done_cyc;
        logic [31:0] last_addr;
        bit          saw_busy, aborted;
        vec_t        v;
        rsp_t        late;

        reset = 1'b1; start = 1'b0; dcrs = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
        tile_ready = 1'b0; perf_model = 0;

        vecs[0] = '{32'h0000_1000, 32'd3,  100, 100, 2, 0,  0, 32'h0000_1010, 32'd3};
        vecs[1] = '{32'h0000_4000, 32'd0,  100, 100, 2, 0,  0, 32'h0,         32'd0};
        vecs[2] = '{32'h0000_8000, 32'd10, 100, 100, 2, 20, 0, 32'h0000_8048, 32'd10};
        vecs[3] = '{32'hFFFF_FFF8, 32'd2,  100, 100, 1, 0,  0, 32'h0000_0000, 32'd2};
        vecs[4] = '{32'h0000_A000, 32'd6,  100, 100, 2, 0,  1, 32'h0000_A028, 32'd6};
        for (int i = 5; i < 10; i++) begin
            v.tbuf     = $urandom;
            v.cnt      = $urandom_range(4, 12);
            v.req_pct  = $urandom_range(40, 100);
            v.tile_pct = $urandom_range(40, 100);
            v.lat      = $urandom_range(1, 4);
            v.hold     = 0;
            v.restart  = $urandom_range(0, 1);
            v.exp_last_addr = v.tbuf + (v.cnt - 32'd1) * 32'(TB);
            v.exp_tiles     = v.cnt;
            vecs[i] = v;
        end

        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_pass(vecs[i], -1, n_tiles, n_reqs, n_done, done_cyc, last_addr, saw_busy, aborted);
            check("tiles_emitted", n_tiles, vecs[i].exp_tiles);
            check("done_pulses", n_done, 1);
            if (vecs[i].cnt != 0) begin
                check("last_req_addr", last_addr, vecs[i].exp_last_addr);
            end else begin
                check("zero_count_reqs", n_reqs, 0);
                check("zero_count_done_cycle", done_cyc, 0);
                check("zero_count_busy", saw_busy, 0);
            end
        end

        // Huge tile count: runs normally until reset abandons it.
        v = '{32'h0001_0000, 32'hFFFF_FFFF, 100, 100, 1, 0, 0, 32'h0, 32'h0};
        run_pass(v, 6, n_tiles, n_reqs, n_done, done_cyc, last_addr, saw_busy, aborted);
        check("huge_aborted", aborted, 1);
        check("huge_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        check_outputs_zero("huge_reset");
        perf_model = 0;
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-pass after two tiles: outputs drop at once, late data is ignored.
        v = '{32'h0000_2000, 32'd5, 100, 100, 2, 0, 0, 32'h0, 32'h0};
        run_pass(v, 2, n_tiles, n_reqs, n_done, done_cyc, last_addr, saw_busy, aborted);
        check("abort_reached", aborted, 1);
        check("abort_tiles", n_tiles, 2);
        late = (rspq.size() > 0) ? rspq[0] : '{addr: 32'h0000_2020, tag: 2'd0, due: 0};
        #1 reset = 1'b1;
        #1;
        check_outputs_zero("mid_pass_reset");
        perf_model = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(late.addr);
            mem_rsp_tag   = late.tag;
            #1;
            check("late_rsp_ready", mem_rsp_ready, 0);
            check("late_tile_valid", tile_valid, 0);
            check("late_done", done, 0);
        end
        mem_rsp_valid = 1'b0;

        v = '{32'h0000_3000, 32'd1, 100, 100, 2, 0, 0, 32'h0000_3000, 32'd1};
        run_pass(v, -1, n_tiles, n_reqs, n_done, done_cyc, last_addr, saw_busy, aborted);
        check("post_reset_tiles", n_tiles, 1);
        check("post_reset_done", n_done, 1);
        check("post_reset_addr", last_addr, v.exp_last_addr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
